// File: rtl/vga_timing_pipe_if.sv
// Signal bundle for vga_timing_pipe: pixel coordinates and strobes out to the
// renderer, colour back from it, and the pixel-aligned video output.
interface vga_timing_pipe_if #(
    parameter int CW = 4
);
    logic              pix_tick;
    logic [10:0]       x;
    logic [10:0]       y;
    logic              active;
    logic              line_start;
    logic              frame_start;
    logic [3*CW-1:0]   rgb_in;
    logic              hsync;
    logic              vsync;
    logic              de;
    logic [3*CW-1:0]   rgb_out;
    logic [15:0]       frame_cnt;

    modport master (
        output pix_tick, x, y, active, line_start, frame_start,
        output hsync, vsync, de, rgb_out, frame_cnt,
        input  rgb_in
    );

    modport slave (
        input  pix_tick, x, y, active, line_start, frame_start,
        input  hsync, vsync, de, rgb_out, frame_cnt,
        output rgb_in
    );
endinterface

// File: rtl/vga_timing_pipe.sv
// Programmable VGA timing generator; sync/DE are delayed PIPE+1 pixel ticks so they
// line up with colour returned by a renderer with PIPE ticks of latency.
module vga_timing_pipe #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 56,
    parameter int H_SYNC   = 120,
    parameter int H_BP     = 64,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 37,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 23,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int CW       = 4,
    parameter int CLK_DIV  = 1,
    parameter int PIPE     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    vga_timing_pipe_if.master     vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        HS_ON    = 1'(HS_POL);
    localparam logic        VS_ON    = 1'(VS_POL);

    localparam int              DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0]   div_r;
    logic            tick_s;
    logic [10:0]     x_r;
    logic [10:0]     y_r;
    logic [15:0]     frame_cnt_r;
    logic            hs_raw_s;
    logic            vs_raw_s;
    logic            active_s;
    logic            line_start_s;
    logic            frame_start_s;
    logic [2:0]      raw_s;
    logic [2:0]      dly_s;
    logic            hsync_r;
    logic            vsync_r;
    logic            de_r;
    logic [3*CW-1:0] rgb_r;

    // Clock divider; the tick is gated by rst so it stays low throughout reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_r <= {DW{1'b0}};
        end else if (tick_s) begin
            div_r <= {DW{1'b0}};
        end else begin
            div_r <= div_r + DW'(1);
        end
    end

    // Pixel tick decode.
    always_comb begin
        tick_s = rst && (div_r == DIV_LAST);
    end

    // Raster counters and completed-frame counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            x_r         <= 11'd0;
            y_r         <= 11'd0;
            frame_cnt_r <= 16'd0;
        end else if (tick_s) begin
            if (x_r == H_LAST) begin
                x_r <= 11'd0;
                if (y_r == V_LAST) begin
                    y_r         <= 11'd0;
                    frame_cnt_r <= frame_cnt_r + 16'd1;
                end else begin
                    y_r <= y_r + 11'd1;
                end
            end else begin
                x_r <= x_r + 11'd1;
            end
        end
    end

    // Undelayed decodes of the current raster position.
    always_comb begin
        hs_raw_s      = (x_r >= HS_START) && (x_r < HS_END);
        vs_raw_s      = (y_r >= VS_START) && (y_r < VS_END);
        active_s      = (x_r < H_ACT) && (y_r < V_ACT);
        line_start_s  = (x_r == 11'd0);
        frame_start_s = (x_r == 11'd0) && (y_r == 11'd0);
        raw_s         = {hs_raw_s, vs_raw_s, active_s};
    end

    // Stages hold un-polarised {hs, vs, active}; all-zero means blanked and idle.
    generate
        if (PIPE == 0) begin : g_nopipe
            assign dly_s = raw_s;
        end else begin : g_pipe
            logic [2:0] stage_r [PIPE];

            // Renderer-latency shift register.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int i = 0; i < PIPE; i++) begin
                        stage_r[i] <= 3'b000;
                    end
                end else if (tick_s) begin
                    stage_r[0] <= raw_s;
                    for (int i = 1; i < PIPE; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign dly_s = stage_r[PIPE-1];
        end
    endgenerate

    // Output register: applies sync polarity and blanks colour outside the active area.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hsync_r <= ~HS_ON;
            vsync_r <= ~VS_ON;
            de_r    <= 1'b0;
            rgb_r   <= {(3*CW){1'b0}};
        end else if (tick_s) begin
            hsync_r <= dly_s[2] ? HS_ON : ~HS_ON;
            vsync_r <= dly_s[1] ? VS_ON : ~VS_ON;
            de_r    <= dly_s[0];
            rgb_r   <= dly_s[0] ? vga.rgb_in : {(3*CW){1'b0}};
        end
    end

    assign vga.pix_tick    = tick_s;
    assign vga.x           = x_r;
    assign vga.y           = y_r;
    assign vga.active      = active_s;
    assign vga.line_start  = line_start_s;
    assign vga.frame_start = frame_start_s;
    assign vga.hsync       = hsync_r;
    assign vga.vsync       = vsync_r;
    assign vga.de          = de_r;
    assign vga.rgb_out     = rgb_r;
    assign vga.frame_cnt   = frame_cnt_r;
endmodule

// File: tb/tb_vga_timing_pipe.sv
// Randomised bench for vga_timing_pipe: two instances (CLK_DIV 1 and 3) compared every
// clock against a raster model computed from the non-reset clock count.
module tb_vga_timing_pipe;
    localparam int   HA = 8, HF = 2, HSW = 3, HB = 1;
    localparam int   VA = 4, VF = 1, VSW = 2, VB = 1;
    localparam int   HT = HA + HF + HSW + HB;
    localparam int   VT = VA + VF + VSW + VB;
    localparam int   PIPE = 2;
    localparam int   CW = 4;
    localparam logic HPOL = 1'b0;
    localparam logic VPOL = 1'b1;

    typedef struct packed {
        logic        tick;
        logic [10:0] x;
        logic [10:0] y;
        logic        act;
        logic        ls;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] rgb;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   k = 0;
    int   total_cnt = 0;
    int   pass_cnt = 0;
    bit   run = 1'b0;
    int   phase = 0;

    always #5 clk = ~clk;

    vga_timing_pipe_if #(.CW(CW)) v1 ();
    vga_timing_pipe_if #(.CW(CW)) v3 ();

    vga_timing_pipe #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(0), .VS_POL(1), .CW(CW), .CLK_DIV(1), .PIPE(PIPE)
    ) dut1 (.clk(clk), .rst(rst), .vga(v1));

    vga_timing_pipe #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(0), .VS_POL(1), .CW(CW), .CLK_DIV(3), .PIPE(PIPE)
    ) dut3 (.clk(clk), .rst(rst), .vga(v3));

    function automatic logic [11:0] col(input int p);
        return 12'(((p / HT) % VT % 16) * 256 + (p % HT) % 16);
    endfunction

    function automatic bit is_act(input int p);
        return ((p % HT) < HA) && (((p / HT) % VT) < VA);
    endfunction

    // Expected outputs after k non-reset clocks, from raster arithmetic alone.
    function automatic exp_t model(input int kk, input int d, input logic r);
        exp_t e;
        int   n, m, px, py;
        e      = '0;
        n      = kk / d;
        e.tick = r && ((kk % d) == (d - 1));
        px     = n % HT;
        py     = (n / HT) % VT;
        e.x    = 11'(px);
        e.y    = 11'(py);
        e.act  = (px < HA) && (py < VA);
        e.ls   = (px == 0);
        e.fs   = (px == 0) && (py == 0);
        e.fc   = 16'((n / (HT * VT)) % 65536);
        m      = n - PIPE - 1;
        if (m < 0) begin
            e.hs  = ~HPOL;
            e.vs  = ~VPOL;
            e.de  = 1'b0;
            e.rgb = 12'd0;
        end else begin
            px    = m % HT;
            py    = (m / HT) % VT;
            e.hs  = (px >= HA + HF && px < HA + HF + HSW) ? HPOL : ~HPOL;
            e.vs  = (py >= VA + VF && py < VA + VF + VSW) ? VPOL : ~VPOL;
            e.de  = is_act(m);
            e.rgb = e.de ? col(m) : 12'd0;
        end
        return e;
    endfunction

    function automatic exp_t pack(input logic t, input logic [10:0] xx, input logic [10:0] yy,
                                  input logic a, input logic l, input logic f, input logic h,
                                  input logic v, input logic dd, input logic [11:0] c,
                                  input logic [15:0] fc);
        exp_t e;
        e = {t, xx, yy, a, l, f, h, v, dd, c, fc};
        return e;
    endfunction

    // Renderer: colour for the pixel PIPE ticks back, noise whenever it is not visible.
    function automatic logic [11:0] drive_col(input int kk, input int d);
        int q;
        q = kk / d - PIPE;
        if (q >= 0 && is_act(q)) return col(q);
        return 12'($urandom);
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s at k=%0d: got %h expected %h", nm, k, got, want);
    endtask

    task automatic step(input logic new_rst);
        @(posedge clk);
        if (!rst) k = 0;
        else k = k + 1;
        #1;
        rst       = new_rst;
        v1.rgb_in = drive_col(k, 1);
        v3.rgb_in = drive_col(k, 3);
    endtask

    // Per-clock comparison of both instances plus fixed points of the first frames.
    always @(negedge clk) begin
        if (run) begin
            chk("dut1", pack(v1.pix_tick, v1.x, v1.y, v1.active, v1.line_start, v1.frame_start,
                             v1.hsync, v1.vsync, v1.de, v1.rgb_out, v1.frame_cnt), model(k, 1, rst));
            chk("dut3", pack(v3.pix_tick, v3.x, v3.y, v3.active, v3.line_start, v3.frame_start,
                             v3.hsync, v3.vsync, v3.de, v3.rgb_out, v3.frame_cnt), model(k, 3, rst));
            if (phase == 1 && rst) begin
                case (k)
                    12:      chk("hsync_before", {63'd0, v1.hsync}, 64'd1);
                    13:      chk("hsync_start", {63'd0, v1.hsync}, 64'd0);
                    15:      chk("hsync_last", {63'd0, v1.hsync}, 64'd0);
                    16:      chk("hsync_end", {63'd0, v1.hsync}, 64'd1);
                    11:      chk("blank_rgb", {51'd0, v1.de, v1.rgb_out}, 64'd0);
                    22:      chk("active_rgb", {51'd0, v1.de, v1.rgb_out}, {51'd0, 1'b1, 12'h105});
                    72:      chk("vsync_before", {63'd0, v1.vsync}, 64'd0);
                    73:      chk("vsync_start", {63'd0, v1.vsync}, 64'd1);
                    112:     chk("frame_wrap", {v1.frame_cnt, v1.frame_start, v1.x, v1.y},
                                 {16'd1, 1'b1, 11'd0, 11'd0});
                    default: ;
                endcase
            end
        end
    end

    initial begin
        exp_t pm;
        int   cnt;
        int   hold;
        v1.rgb_in = 12'd0;
        v3.rgb_in = 12'd0;

        pm = model(13, 1, 1'b1);
        chk("pin_hs_start", {63'd0, pm.hs}, 64'd0);
        pm = model(16, 1, 1'b1);
        chk("pin_hs_end", {63'd0, pm.hs}, 64'd1);
        pm = model(22, 1, 1'b1);
        chk("pin_rgb", {51'd0, pm.de, pm.rgb}, {51'd0, 1'b1, 12'h105});
        pm = model(112, 1, 1'b1);
        chk("pin_frame", {pm.fc, pm.fs, pm.x, pm.y}, {16'd1, 1'b1, 11'd0, 11'd0});
        pm = model(5, 3, 1'b1);
        chk("pin_div", {pm.tick, pm.x}, {1'b1, 11'd1});
        pm = model(0, 1, 1'b0);
        chk("pin_rst", pm, {1'b0, 11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 16'd0});
        cnt = 0;
        for (int n = PIPE + 1; n < PIPE + 1 + HT * VT; n++) begin
            pm = model(n, 1, 1'b1);
            if (pm.vs) cnt++;
        end
        chk("pin_vs_len", 64'(cnt), 64'd28);

        rst = 1'b0;
        repeat (5) step(1'b0);
        @(negedge clk);
        chk("reset_vals", {v1.pix_tick, v1.x, v1.y, v1.hsync, v1.vsync, v1.de, v1.rgb_out, v1.frame_cnt},
            {1'b0, 11'd0, 11'd0, 1'b1, 1'b0, 1'b0, 12'd0, 16'd0});
        run   = 1'b1;
        phase = 1;
        step(1'b1);
        for (int i = 0; i < 2000 && k < 2 * HT * VT + 81; i++) step(1'b1);

        // Abort mid-frame while dut1 is at x=11, y=5 (inside hsync).
        phase = 2;
        rst   = 1'b0;
        step(1'b0);
        @(negedge clk);
        chk("mid_rst", {v1.hsync, v1.de, v1.x, v1.y}, {1'b1, 1'b0, 11'd0, 11'd0});
        step(1'b0);
        step(1'b1);
        @(negedge clk);
        chk("first_tick", {v1.pix_tick, v1.x, v1.y, v1.frame_start, v1.frame_cnt},
            {1'b1, 11'd0, 11'd0, 1'b1, 16'd0});

        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!rst) begin
                if (hold > 0) begin
                    hold--;
                    step(1'b0);
                end else begin
                    step(1'b1);
                end
            end else if ($urandom_range(0, 999) == 0) begin
                hold = int'($urandom_range(0, 3));
                step(1'b0);
            end else begin
                step(1'b1);
            end
        end
        @(negedge clk);
        run = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/vga_timing_pipe.md
Name: vga_timing_pipe

Overview:
- Parametrised successor to the fixed 800x600 VGA timing and render block.
- Generates H/V counters, sync pulses, data-enable and frame/line strobes from a programmable pixel-clock enable.
- Supports configurable sync polarity and colour depth.
- Delays sync/DE through a PIPE-deep pipeline so a downstream renderer (board, bricks, ball) can take PIPE pixel ticks to return colour while hsync/vsync/rgb_out stay pixel-aligned.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 56, horizontal front porch (pixels)
- H_SYNC, 120, hsync width (pixels)
- H_BP, 64, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 23, vertical back porch (lines)
- HS_POL, 1, hsync asserted level (1 = active-high, 0 = active-low)
- VS_POL, 1, vsync asserted level
- CW, 4, bits per colour channel
- CLK_DIV, 1, clk cycles per pixel (1..16)
- PIPE, 2, renderer latency in pixel ticks (0..7)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- pix_tick  out  1  one-clk pulse per pixel; all pixel-domain state advances only on it
- x  out  11  current horizontal count (0..H_TOTAL-1), to renderer
- y  out  11  current vertical count (0..V_TOTAL-1), to renderer
- active  out  1  (x < H_ACTIVE) && (y < V_ACTIVE) for current x,y
- line_start  out  1  high for the tick where x==0
- frame_start  out  1  high for the tick where x==0 && y==0
- rgb_in  in  3*CW  renderer colour {R,G,B}, valid PIPE ticks after the matching x,y
- hsync  out  1  aligned horizontal sync
- vsync  out  1  aligned vertical sync
- de  out  1  aligned data enable
- rgb_out  out  3*CW  aligned colour, forced 0 when de==0
- frame_cnt  out  16  completed-frame counter

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. All compares use 11-bit unsigned arithmetic; each total must be ≤ 2047.
- Tick divider:
  - div counts 0..CLK_DIV-1; pix_tick=1 when div==CLK_DIV-1.
  - CLK_DIV=1 gives pix_tick constantly 1 outside reset.
- Counters (registered, update on pix_tick only):
  - x increments; at H_TOTAL-1 it wraps to 0 and y increments.
  - y wraps to 0 at V_TOTAL-1 when x also wraps.
  - No other wrap points.
- Raw sync is computed from current x,y:
  - hs_raw = (x ≥ H_ACTIVE+H_FP) && (x < H_ACTIVE+H_FP+H_SYNC).
  - vs_raw uses the same form on y.
  - active, line_start and frame_start are combinational decodes of registered x,y.
- Alignment pipeline:
  - {hs_raw, vs_raw, active} pass through a PIPE-stage shift register, advanced on pix_tick, followed by one output register.
  - Output register, on pix_tick: hsync = HS_POL ? hs_d : ~hs_d; vsync likewise with VS_POL; de = act_d; rgb_out = act_d ? rgb_in : 0.
  - Total latency from x,y to matching outputs is PIPE+1 ticks. PIPE=0 means the output register only.
- frame_cnt increments (mod 2^16) on the pix_tick where x==H_TOTAL-1 && y==V_TOTAL-1.
- Reset (rst==0 sampled at posedge clk):
  - div=0, x=0, y=0, frame_cnt=0, de=0, rgb_out=0.
  - hsync=~HS_POL, vsync=~VS_POL (deasserted).
  - All pipeline stages cleared to inactive.
  - pix_tick=0 during reset.
- Reset mid-frame aborts the frame immediately; no partial sync pulse survives. After release, the first pix_tick occurs CLK_DIV clocks later with x=0,y=0 and frame_start=1.
- rgb_in is ignored whenever the delayed active flag is 0, including during porches and sync.
- Outputs hold their values between pix_ticks.

Test Plan:
- Reset values: params H 8/2/3/1, V 4/1/2/1, HS_POL=0, VS_POL=1, CLK_DIV=1, PIPE=2; hold rst=0 for 5 clk -> x=y=0, hsync=1, vsync=0, de=0, rgb_out=0, frame_cnt=0, pix_tick=0.
- Line timing (same params): release rst, run 14 ticks -> x sequence 0..13 then 0; y increments to 1 on the wrap; line_start high at x=0 only; hsync low for exactly 3 ticks, starting 3 ticks after x==10.
- Pipeline alignment: renderer returns rgb_in = x (padded) with 2-tick delay -> rgb_out equals the x of the pixel shown, de high for 8 consecutive ticks per active line, rgb_out=0 during blanking even with rgb_in=12'hFFF.
- Divider: CLK_DIV=3 -> pix_tick high 1 of every 3 clk; x advances every 3 clk; outputs stable between ticks.
- Frame wrap: run 112 ticks (14x8) -> frame_start at tick 0 and tick 112; frame_cnt=1; vsync high for 2 lines (28 ticks). Preload 65535 frames -> frame_cnt wraps to 0.
- Reset mid-frame: assert rst at x=11,y=5 (inside hsync) -> next clk hsync=1 (deasserted), de=0. After release, first tick has x=0,y=0, frame_start=1; frame_cnt=0.
